// File: rtl/exception_controller_if.sv
// Bundle of request, mask, redirect handshake and status signals between the
// exception controller and the decode/execute trigger and PC-select logic.
interface exception_controller_if #(
  parameter int EXC_COUNT  = 8,
  parameter int ADDR_WIDTH = 32
);
  localparam int CW = (EXC_COUNT > 1) ? $clog2(EXC_COUNT) : 1;

  logic [EXC_COUNT-1:0]  exc_req;
  logic [EXC_COUNT-1:0]  exc_mask;
  logic [ADDR_WIDTH-1:0] current_pc;
  logic [ADDR_WIDTH-1:0] vector_base;
  logic                  eret;
  logic                  take_valid;
  logic                  take_ready;
  logic [ADDR_WIDTH-1:0] vector_addr;
  logic [CW-1:0]         cause;
  logic [ADDR_WIDTH-1:0] epc;
  logic [3:0]            depth;
  logic [EXC_COUNT-1:0]  pending;
  logic                  double_fault;

  // Controller side: offers exceptions and reports status.
  modport master (
    input  exc_req, exc_mask, current_pc, vector_base, eret, take_ready,
    output take_valid, vector_addr, cause, epc, depth, pending, double_fault
  );

  // Pipeline side: raises requests and accepts redirects.
  modport slave (
    output exc_req, exc_mask, current_pc, vector_base, eret, take_ready,
    input  take_valid, vector_addr, cause, epc, depth, pending, double_fault
  );
endinterface

// File: rtl/exception_controller.sv
// Exception controller: latches per-source requests, selects the lowest-index
// eligible source, offers it through a valid/ready redirect handshake, and
// tracks handler nesting depth with a sticky double-fault on overflow.
module exception_controller #(
  parameter int                   EXC_COUNT    = 8,
  parameter int                   ADDR_WIDTH   = 32,
  parameter int                   VECTOR_SHIFT = 4,
  parameter int                   NEST_DEPTH   = 2,
  parameter logic [EXC_COUNT-1:0] NONMASKABLE  = 8'b0000_0011
) (
  input  logic                   clk,
  input  logic                   reset_n,
  exception_controller_if.master bus
);

  localparam int                   CW        = (EXC_COUNT > 1) ? $clog2(EXC_COUNT) : 1;
  localparam logic [3:0]           DEPTH_MAX = 4'(NEST_DEPTH);
  localparam logic [EXC_COUNT-1:0] ONE_HOT0  = EXC_COUNT'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [EXC_COUNT-1:0]  pending_r;
  logic [CW-1:0]         cause_r;
  logic [ADDR_WIDTH-1:0] epc_r;
  logic [3:0]            depth_r;
  logic                  double_fault_r;

  logic [EXC_COUNT-1:0]  eligible_s;
  logic                  any_elig_s;
  logic                  room_s;
  logic [CW-1:0]         sel_idx_s;
  logic                  take_valid_s;
  logic                  handshake_s;
  logic                  select_s;
  logic                  df_set_s;
  logic                  eret_dec_s;
  logic [EXC_COUNT-1:0]  clear_s;

  // Index of the lowest set bit (highest priority); zero when nothing is set.
  function automatic logic [CW-1:0] lowest_set(input logic [EXC_COUNT-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = EXC_COUNT - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = CW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign eligible_s = pending_r & (bus.exc_mask | NONMASKABLE);
  assign any_elig_s = |eligible_s;
  assign room_s     = (depth_r < DEPTH_MAX);
  assign sel_idx_s  = lowest_set(eligible_s);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: start an offer when something is eligible and nesting allows,
  // return to idle once the pipeline accepts the redirect.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_elig_s && room_s) begin
          state_next_s = ST_OFFER;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (bus.take_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OFFER;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes; eret only counts outside an offer and is dropped otherwise.
  always_comb begin
    take_valid_s = 1'b0;
    handshake_s  = 1'b0;
    select_s     = 1'b0;
    df_set_s     = 1'b0;
    eret_dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        select_s   = any_elig_s && room_s;
        df_set_s   = any_elig_s && !room_s;
        eret_dec_s = bus.eret && (depth_r != 4'd0);
      end
      ST_OFFER: begin
        take_valid_s = 1'b1;
        handshake_s  = bus.take_ready;
      end
      default: begin
        take_valid_s = 1'b0;
      end
    endcase
  end

  // One-hot clear of the accepted source.
  always_comb begin
    if (handshake_s) begin
      clear_s = ONE_HOT0 << cause_r;
    end else begin
      clear_s = '0;
    end
  end

  // Pending capture, cause/epc capture, nesting depth and sticky double-fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r      <= '0;
      cause_r        <= '0;
      epc_r          <= '0;
      depth_r        <= 4'd0;
      double_fault_r <= 1'b0;
    end else begin
      pending_r <= (pending_r | bus.exc_req) & ~clear_s;
      if (select_s) begin
        cause_r <= sel_idx_s;
      end
      if (handshake_s) begin
        epc_r   <= bus.current_pc;
        depth_r <= depth_r + 4'd1;
      end else if (eret_dec_s) begin
        depth_r <= depth_r - 4'd1;
      end
      if (df_set_s) begin
        double_fault_r <= 1'b1;
      end
    end
  end

  assign bus.take_valid   = take_valid_s;
  assign bus.cause        = cause_r;
  assign bus.vector_addr  = bus.vector_base + (ADDR_WIDTH'(cause_r) << VECTOR_SHIFT);
  assign bus.epc          = epc_r;
  assign bus.depth        = depth_r;
  assign bus.pending      = pending_r;
  assign bus.double_fault = double_fault_r;

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Parametrised successor to the fixed five-bit exception trigger bus: EXC_COUNT exception request lines, each latched into a pending register.
- Fixed-priority selection with per-source masking; one exception presented at a time to the fetch/redirect stage through a valid/ready handshake.
- Tracks handler nesting depth, captures cause and exception PC, and raises a sticky double-fault when nesting overflows.
- Sits between the decode/execute trigger logic and the PC-select/flush logic of cpu32e2.

Parameters:
- EXC_COUNT, 8, number of exception sources; index 0 is highest priority.
- ADDR_WIDTH, 32, width of PC, vector base and vector address.
- VECTOR_SHIFT, 4, log2 of the byte spacing between handler vectors.
- NEST_DEPTH, 2, maximum handler nesting level (1..15).
- NONMASKABLE, 8'b0000_0011, EXC_COUNT-bit set of sources that ignore exc_mask.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- exc_req  in  EXC_COUNT  per-source trigger; any pulse width; multiple bits may be set.
- exc_mask  in  EXC_COUNT  1 = source enabled; sampled at selection time.
- current_pc  in  ADDR_WIDTH  PC of the instruction in flight; captured into epc on take.
- vector_base  in  ADDR_WIDTH  handler table base address.
- eret  in  1  single-cycle return-from-exception pulse.
- take_valid  out  1  an exception is being offered.
- take_ready  in  1  pipeline accepts the redirect.
- vector_addr  out  ADDR_WIDTH  handler address of the offered exception.
- cause  out  $clog2(EXC_COUNT)  index of the offered or last-taken exception.
- epc  out  ADDR_WIDTH  PC captured on the last take.
- depth  out  4  current nesting level.
- pending  out  EXC_COUNT  pending register contents.
- double_fault  out  1  sticky overflow flag.

Behaviour:
- Reset (asynchronous, reset_n low): pending=0, state=IDLE, take_valid=0, cause=0, epc=0, depth=0, double_fault=0, vector_addr=vector_base.
- Capture: pending <= (pending | exc_req) & ~clear every cycle. A request is never lost; requests for an already-pending bit merge.
- Eligible set = pending & (exc_mask | NONMASKABLE). Selected = lowest set index.
- States:
  - IDLE: if eligible != 0 and depth < NEST_DEPTH -> OFFER, latching sel_idx.
  - OFFER: take_valid=1, cause=sel_idx and vector_addr = vector_base + (sel_idx << VECTOR_SHIFT) (mod 2^ADDR_WIDTH) are held stable until the handshake.
    - take_valid && take_ready: clear pending[sel_idx], epc <= current_pc, depth++, -> IDLE.
    - A higher-priority request arriving during OFFER does not preempt the offer; it waits for the next selection.
  - eligible != 0 with depth == NEST_DEPTH in IDLE: set double_fault (sticky until reset), leave pending untouched, no offer.
- Latency: a request with pending empty and IDLE gives take_valid on the 2nd rising edge after exc_req is asserted (capture, then select). With take_ready held high, the handshake completes on the following edge.
- eret:
  - depth>0 and state!=OFFER: depth-- next edge.
  - depth==0: ignored.
  - In OFFER: ignored; eret is dropped, not deferred.
- Same cycle eret in IDLE plus new request: decrement and capture both happen; selection uses the new depth on the next cycle.
- Masking a source during OFFER does not retract the offer.
- Mask changes only affect subsequent selections; masked sources stay pending.
- epc and cause hold their last-taken values in IDLE.

Test Plan:
- Reset mid-OFFER (reset_n low, pending=8'h04) -> all outputs return to reset values asynchronously. Once reset is released, pending=0 and take_valid=0.
- exc_req=8'h24 one cycle, mask=8'hFF, vector_base=32'h1000, take_ready=1 -> first take cause=2, vector_addr=32'h1020, epc=current_pc. Second take (after eret) cause=5, vector_addr=32'h1050.
- exc_req=8'h10, mask=8'h00 -> no take_valid for 20 cycles, pending=8'h10. Setting mask bit 4 -> take_valid two cycles later with cause=4.
- NONMASKABLE bit 1 with mask=8'h00 and exc_req=8'h02 -> taken, cause=1.
- Three nested takes with no eret at NEST_DEPTH=2 -> depth=2, third request leaves double_fault=1 and take_valid=0. A subsequent eret drops depth to 1 while double_fault stays 1.
- take_ready=0 for 5 cycles while exc_req=8'h01 arrives during an offer of cause 3 -> cause=3 and vector_addr stay stable throughout. After the handshake, the next offer is cause=0.
